mc_controller: RTL

Multicycle control unit for the ASIP datapath, replacing the single-cycle instruction decoder. A registered state machine sequences fetch, decode, execute, memory and writeback over several cycles, waits on a memory ready handshake, and gates architectural writes with the condition result. It sits between the instruction register fields and the shared-memory multicycle datapath.

---
 rtl/mc_pkg.sv | 63 ++++++
 rtl/mc_controller_if.sv | 45 ++++
 rtl/mc_alu_dec.sv | 39 +++
 rtl/mc_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg
// Shared definitions for the multicycle control unit.
//   - state_t: controller state encoding (TRAP state only exists when
//     MC_CONTROLLER_TRAP_EN is defined)
//   - instruction class (Tipo) and data-processing command encodings
//   - datapath select encodings: ALUControl, ResultSrc, ALUSrcB, ImmSrc
//   - isIllegal(): decides whether a Tipo/command pair has no legal meaning
// Configuration macro: MC_CONTROLLER_TRAP_EN
package mc_pkg;

  // Instruction class, IR[16:15]
  localparam logic [1:0] TIPO_DP  = 2'b00;
  localparam logic [1:0] TIPO_MEM = 2'b01;
  localparam logic [1:0] TIPO_BR  = 2'b10;
  localparam logic [1:0] TIPO_ILL = 2'b11;

  // Data-processing command, IR[13:12]
  localparam logic [1:0] CMD_ADD = 2'b00;
  localparam logic [1:0] CMD_SUB = 2'b01;
  localparam logic [1:0] CMD_CMP = 2'b10;
  localparam logic [1:0] CMD_ILL = 2'b11;

  // ALU operation
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  // Result multiplexer
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU B operand
  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_ONE = 2'b10;

  // Immediate extension
  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_BRANCH
`ifdef MC_CONTROLLER_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  // Class 11 is never legal; inside data processing only command 11 is.
  function automatic logic isIllegal(input logic [1:0] tipo, input logic [1:0] cmd);
    return (tipo == TIPO_ILL) || ((tipo == TIPO_DP) && (cmd == CMD_ILL));
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if
// Bundles the instruction-field inputs, the memory handshake and every
// datapath control line between the controller and the datapath.
//   Fields in : Tipo[1:0], currentInstr[2:0], Rd[RD_W-1:0], CondEx
//   Handshake : MemReady (in to controller), MemReq/MemW (out)
//   Controls  : IRWrite, PCWrite, AdrSrc, RegW, ALUSrcA, ALUSrcB, ResultSrc,
//               ALUControl, ImmSrc, RegSrc, FlagW, NoWrite, Trap
// Modports: master = controller side, slave = datapath side.
interface mc_controller_if #(
  parameter int RD_W = 4
);
  logic [1:0]      Tipo;
  logic [2:0]      currentInstr;
  logic [RD_W-1:0] Rd;
  logic            CondEx;
  logic            MemReady;

  logic            MemReq;
  logic            MemW;
  logic            IRWrite;
  logic            PCWrite;
  logic            AdrSrc;
  logic            RegW;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      ResultSrc;
  logic [1:0]      ALUControl;
  logic [1:0]      ImmSrc;
  logic [1:0]      RegSrc;
  logic [1:0]      FlagW;
  logic            NoWrite;
  logic            Trap;

  modport master (
    input  Tipo, currentInstr, Rd, CondEx, MemReady,
    output MemReq, MemW, IRWrite, PCWrite, AdrSrc, RegW, ALUSrcA, ALUSrcB,
           ResultSrc, ALUControl, ImmSrc, RegSrc, FlagW, NoWrite, Trap
  );

  modport slave (
    output Tipo, currentInstr, Rd, CondEx, MemReady,
    input  MemReq, MemW, IRWrite, PCWrite, AdrSrc, RegW, ALUSrcA, ALUSrcB,
           ResultSrc, ALUControl, ImmSrc, RegSrc, FlagW, NoWrite, Trap
  );
endinterface

// File: rtl/mc_alu_dec.sv
// mc_alu_dec
// Combinational ALU decoder for the controller.
//   i_cmd        : data-processing command, IR[13:12]
//   i_aluOp      : 1 when the controller is in an execute state; otherwise
//                  the ALU just adds and no flags are touched
//   i_condEx     : condition result, gates the flag update of CMP
//   o_aluControl : ALU operation
//   o_flagW      : flag write enables
//   o_noWrite    : suppresses register writeback (CMP)
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [1:0] i_cmd,
  input  logic       i_aluOp,
  input  logic       i_condEx,
  output logic [1:0] o_aluControl,
  output logic [1:0] o_flagW,
  output logic       o_noWrite
);

  // Only CMP touches flags; a failed condition must leave them untouched.
  always_comb begin
    o_aluControl = ALU_ADD;
    o_flagW      = 2'b00;
    o_noWrite    = 1'b0;
    if (i_aluOp) begin
      case (i_cmd)
        CMD_SUB: o_aluControl = ALU_SUB;
        CMD_CMP: begin
          o_aluControl = ALU_SUB;
          o_flagW      = i_condEx ? 2'b11 : 2'b00;
          o_noWrite    = i_condEx;
        end
        default: o_aluControl = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller
// Multicycle control unit: sequences fetch, decode, execute, memory and
// writeback, waits on MemReady, and gates architectural writes with CondEx.
//   clk   : clock
//   reset : synchronous, active-high; strobes are forced low while asserted
//   bus   : mc_controller_if.master (instruction fields, memory handshake,
//           datapath controls)
// Parameters: RD_W register index width, PC_IDX register index aliasing PC.
// Configuration macro: MC_CONTROLLER_TRAP_EN -- when defined an illegal
// instruction parks the controller in TRAP with Trap=1 until reset; when
// undefined it falls through as a two-cycle NOP and Trap is tied low.
module mc_controller
  import mc_pkg::*;
#(
  parameter int RD_W   = 4,
  parameter int PC_IDX = 15
)(
  input logic        clk,
  input logic        reset,
  mc_controller_if.master bus
);

  state_t     r_state;

  logic       w_iBit;
  logic [1:0] w_cmd;
  logic       w_isLoad;
  logic       w_illegal;
  logic       w_rdIsPc;
  logic       w_aluOp;
  logic [1:0] w_aluControl;
  logic [1:0] w_flagW;
  logic       w_noWrite;

  assign w_iBit    = bus.currentInstr[2];
  assign w_cmd     = bus.currentInstr[1:0];
  assign w_isLoad  = bus.currentInstr[0];
  assign w_illegal = isIllegal(bus.Tipo, w_cmd);
  assign w_rdIsPc  = (bus.Rd == RD_W'(PC_IDX));
  assign w_aluOp   = (r_state == S_EXECR) || (r_state == S_EXECI);

  mc_alu_dec u_aluDec (
    .i_cmd        (w_cmd),
    .i_aluOp      (w_aluOp),
    .i_condEx     (bus.CondEx),
    .o_aluControl (w_aluControl),
    .o_flagW      (w_flagW),
    .o_noWrite    (w_noWrite)
  );

  // State sequencing. Memory states hold until MemReady; a store whose
  // condition failed never issues its request and returns straight to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  if (bus.MemReady) r_state <= S_DECODE;
        S_DECODE: begin
          if (w_illegal) begin
`ifdef MC_CONTROLLER_TRAP_EN
            r_state <= S_TRAP;
`else
            r_state <= S_FETCH;
`endif
          end else begin
            case (bus.Tipo)
              TIPO_DP:  r_state <= w_iBit ? S_EXECI : S_EXECR;
              TIPO_MEM: r_state <= S_MEMADR;
              TIPO_BR:  r_state <= S_BRANCH;
              default:  r_state <= S_FETCH;
            endcase
          end
        end
        S_EXECR,
        S_EXECI:  r_state <= (w_cmd == CMD_CMP) ? S_FETCH : S_ALUWB;
        S_ALUWB:  r_state <= S_FETCH;
        S_MEMADR: begin
          if (w_isLoad)        r_state <= S_MEMRD;
          else if (bus.CondEx) r_state <= S_MEMWR;
          else                 r_state <= S_FETCH;
        end
        S_MEMRD:  if (bus.MemReady) r_state <= S_MEMWB;
        S_MEMWB:  r_state <= S_FETCH;
        S_MEMWR:  if (bus.MemReady || !bus.CondEx) r_state <= S_FETCH;
        S_BRANCH: r_state <= S_FETCH;
`ifdef MC_CONTROLLER_TRAP_EN
        S_TRAP:   r_state <= S_TRAP;
`endif
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Control outputs decoded from the current state and instruction fields.
  // While reset is high the datapath sees FETCH selects but no strobes, so
  // an aborted instruction cannot write anything on the way out.
  always_comb begin
    bus.MemReq     = 1'b0;
    bus.MemW       = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.RegW       = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = SRCB_REG;
    bus.ResultSrc  = RES_ALUOUT;
    bus.ALUControl = w_aluControl;
    bus.ImmSrc     = IMM_DP;
    bus.RegSrc     = 2'b00;
    bus.FlagW      = w_flagW;
    bus.NoWrite    = w_noWrite;
    bus.Trap       = 1'b0;

    if (reset) begin
      bus.ALUSrcA    = 1'b1;
      bus.ALUSrcB    = SRCB_ONE;
      bus.ResultSrc  = RES_ALURESULT;
      bus.ALUControl = ALU_ADD;
      bus.FlagW      = 2'b00;
      bus.NoWrite    = 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          bus.MemReq    = 1'b1;
          bus.IRWrite   = bus.MemReady;
          bus.PCWrite   = bus.MemReady;
          bus.ALUSrcA   = 1'b1;
          bus.ALUSrcB   = SRCB_ONE;
          bus.ResultSrc = RES_ALURESULT;
        end
        S_DECODE: begin
          bus.ALUSrcA   = 1'b1;
          bus.ALUSrcB   = SRCB_ONE;
          bus.ResultSrc = RES_ALURESULT;
        end
        S_EXECR: bus.ALUSrcB = SRCB_REG;
        S_EXECI: bus.ALUSrcB = SRCB_IMM;
        S_ALUWB: begin
          bus.ResultSrc = RES_ALUOUT;
          bus.RegW      = bus.CondEx && !w_rdIsPc;
          bus.PCWrite   = bus.CondEx && w_rdIsPc;
        end
        S_MEMADR: begin
          bus.ALUSrcB = SRCB_IMM;
          bus.ImmSrc  = IMM_MEM;
        end
        S_MEMRD: begin
          bus.MemReq = 1'b1;
          bus.AdrSrc = 1'b1;
        end
        S_MEMWB: begin
          bus.ResultSrc = RES_READDATA;
          bus.RegW      = bus.CondEx && !w_rdIsPc;
          bus.PCWrite   = bus.CondEx && w_rdIsPc;
        end
        S_MEMWR: begin
          bus.MemReq = 1'b1;
          bus.AdrSrc = 1'b1;
          bus.RegSrc = 2'b10;
          bus.MemW   = bus.CondEx;
        end
        S_BRANCH: begin
          bus.ALUSrcA   = 1'b1;
          bus.ALUSrcB   = SRCB_IMM;
          bus.ImmSrc    = IMM_BR;
          bus.RegSrc    = 2'b01;
          bus.ResultSrc = RES_ALURESULT;
          bus.PCWrite   = bus.CondEx;
        end
`ifdef MC_CONTROLLER_TRAP_EN
        S_TRAP: bus.Trap = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule
